// File: rtl/array_sequencer.sv
// array_sequencer: moves words between a stream interface and an external
// array. A load command streams in_data words into consecutive entries; a
// dump command streams consecutive entries out on out_data. Entry indices
// start at cmd_base mod depth and wrap at depth.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_op/cmd_base/cmd_count     0=load 1=dump, first entry, beat count
//   in_valid/in_ready/in_data     load stream
//   out_valid/out_ready/out_data  dump stream, out_last on the final beat
//   done                          one-cycle completion pulse
//   arr_write/arr_index           array write enable and entry index
//   arr_datain/arr_dataout        array write data, combinational read data
module array_sequencer #(
  parameter int unsigned width = 32,
  parameter int unsigned depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_op,
  input  logic [7:0]       cmd_base,
  input  logic [7:0]       cmd_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             arr_write,
  output logic [7:0]       arr_index,
  output logic [width-1:0] arr_datain,
  input  logic [width-1:0] arr_dataout
);

  localparam int unsigned IDX_W = 8;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(depth - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DUMP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_ptr_nxt;
  logic [IDX_W-1:0] r_remaining;
  logic [IDX_W-1:0] w_remaining_nxt;
  logic [IDX_W-1:0] w_base_mod;
  logic [IDX_W-1:0] w_ptr_inc;
  logic             w_beat;

  // Starting entry folded into the array range.
  assign w_base_mod = IDX_W'(32'(cmd_base) % depth);

  // Pointer advance with wrap at the top of the array.
  assign w_ptr_inc = (r_ptr == LAST_IDX) ? '0 : r_ptr + IDX_W'(1);

  // State and command bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next-state and output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_remaining_nxt = r_remaining;
    w_beat          = 1'b0;
    cmd_ready       = 1'b0;
    in_ready        = 1'b0;
    out_valid       = 1'b0;
    out_data        = '0;
    out_last        = 1'b0;
    done            = 1'b0;
    arr_write       = 1'b0;
    arr_index       = '0;
    arr_datain      = '0;

    case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_ptr_nxt       = w_base_mod;
          w_remaining_nxt = cmd_count;
          if (cmd_count == '0) begin
            w_state_nxt = DONE;
          end else if (cmd_op) begin
            w_state_nxt = DUMP;
          end else begin
            w_state_nxt = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready   = 1'b1;
        arr_write  = in_valid;
        arr_datain = in_data;
        arr_index  = r_ptr;
        w_beat     = in_valid;
      end
      DUMP: begin
        out_valid = 1'b1;
        out_data  = arr_dataout;
        out_last  = (r_remaining == IDX_W'(1));
        arr_index = r_ptr;
        w_beat    = out_ready;
      end
      DONE: begin
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // A beat advances the pointer; the final beat closes the command.
    if (w_beat) begin
      w_ptr_nxt       = w_ptr_inc;
      w_remaining_nxt = r_remaining - IDX_W'(1);
      if (r_remaining == IDX_W'(1)) begin
        w_state_nxt = DONE;
      end
    end

    // Reset suppresses all handshakes and side effects in the same cycle.
    if (reset) begin
      cmd_ready = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      done      = 1'b0;
      arr_write = 1'b0;
    end
  end

endmodule

// File: doc/array_sequencer.md
ARRAY_SEQUENCER -- requirements
Module: array_sequencer

Interface
REQ-001 The block SHALL have parameter width, default 32, meaning the data word width in bits.
REQ-002 The block SHALL have parameter depth, default 8, meaning the number of array entries addressed (1..256).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high. Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_op  input  1  0 = load (stream into array), 1 = dump (array out to stream).
- cmd_base  input  8  first entry index.
- cmd_count  input  8  number of beats, 0..255.
- in_valid  input  1  load-stream data valid.
- in_ready  output  1  load-stream data accepted.
- in_data  input  width  load-stream word.
- out_valid  output  1  dump-stream data valid.
- out_ready  input  1  dump-stream sink ready.
- out_data  output  width  dump-stream word.
- out_last  output  1  final dump beat.
- done  output  1  one-cycle command-complete pulse.
- arr_write  output  1  array write enable.
- arr_index  output  8  array entry index.
- arr_datain  output  width  array write data.
- arr_dataout  input  width  array read data, combinational from arr_index.

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, DUMP, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-005 On cmd_valid & cmd_ready, the block SHALL latch op, base mod depth as ptr, count as remaining; next state: DONE if count = 0, else LOAD (op 0) or DUMP (op 1).
REQ-006 arr_index SHALL equal ptr in LOAD and DUMP, and 0 in IDLE and DONE.
REQ-007 In LOAD, in_ready SHALL be 1; arr_write SHALL equal in_valid (combinational); arr_datain SHALL equal in_data; outside LOAD, arr_write and in_ready SHALL be 0 and arr_datain SHALL be 0.
REQ-008 In DUMP, out_valid SHALL be 1 and out_data SHALL equal arr_dataout; outside DUMP, out_valid SHALL be 0, out_data 0, out_last 0.
REQ-009 A beat SHALL be in_valid & in_ready (LOAD) or out_valid & out_ready (DUMP); each beat SHALL advance ptr and decrement remaining by 1 at the next clock edge.
REQ-010 ptr SHALL wrap from depth-1 to 0; counts greater than depth SHALL wrap and revisit entries.
REQ-011 out_last SHALL be 1 in DUMP when remaining = 1.
REQ-012 On the beat where remaining = 1, the next state SHALL be DONE; with no beat, state, ptr, remaining, arr_index and out_data SHALL hold (stall-stable).
REQ-013 DONE SHALL last exactly one cycle with done = 1, then go to IDLE; done SHALL be 0 in all other states.
REQ-014 A new command SHALL NOT be accepted before the cycle after DONE; back-to-back commands SHALL therefore be separated by at least one IDLE cycle.
REQ-015 Load-beat latency: a word accepted at edge N SHALL be readable from the array at arr_index in the cycle after edge N.

Reset
REQ-016 While reset is high, state SHALL go to IDLE at the next edge and arr_write, in_ready, out_valid, out_last, done SHALL be forced to 0 combinationally in that cycle.
REQ-017 After reset, outputs SHALL be: cmd_ready 1, in_ready 0, out_valid 0, out_data 0, out_last 0, done 0, arr_write 0, arr_index 0, arr_datain 0.
REQ-018 Reset during LOAD or DUMP SHALL abort the command with no done pulse; entries already written SHALL remain.

Verification
REQ-019 Load base 2, count 3, words A,B,C with in_valid continuous -> arr_write on 3 consecutive cycles at indices 2,3,4; done one cycle after third beat.
REQ-020 Dump base 6, count 4, depth 8, out_ready toggling 1,0,1,0,... -> indices 6,7,0,1 emitted in order, out_data stable across stalls, out_last only on index-1 beat.
REQ-021 Command count 0 (either op) -> no arr_write, no out_valid; done pulses the cycle after acceptance; cmd_ready high the following cycle.
REQ-022 Load base 0, count 10, depth 8 -> entries 0,1 hold beats 8,9; entries 2..7 hold beats 2..7; subsequent dump count 8 returns that content.
REQ-023 Reset asserted after 2 of 5 load beats -> next cycle IDLE, cmd_ready 1, done never pulses; dump of entries 0,1 returns the two written words.
REQ-024 cmd_valid held high during LOAD and during DONE -> second command accepted only in the IDLE cycle following done.
